// File: rtl/async_fifo_gray_ptr_sync.sv
// ============================================================================
// Module   : async_fifo_gray_ptr_sync
// Brief    : Gray-pointer synchronizer with binary conversion, update pulse and
//            single-bit-change violation monitor for async FIFO pointers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_gray_ptr_sync #(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PTR_W-1:0]     ptr_gray_i,
    input  logic                 err_clr_i,
    output logic [PTR_W-1:0]     ptr_gray_o,
    output logic [PTR_W-1:0]     ptr_bin_o,
    output logic                 ptr_upd_o,
    output logic                 gray_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || PTR_W < 2 || ERR_CNT_W < 1) begin : g_param_check
            $error("async_fifo_gray_ptr_sync: illegal parameters PTR_W=%0d SYNC_STAGES=%0d ERR_CNT_W=%0d",
                   PTR_W, SYNC_STAGES, ERR_CNT_W);
        end
    endgenerate

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];

    // Plain flop chain; each bit is synchronized independently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q[0] <= '0;
        end else begin
            sync_q[0] <= ptr_gray_i;
        end
    end

    generate
        for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_stage
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q[k] <= '0;
                end else begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end
    endgenerate

    assign ptr_gray_o = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits at or above i.
    logic [PTR_W-1:0] bin_next;
    always_comb begin
        bin_next = '0;
        for (int i = 0; i < PTR_W; i++) begin
            bin_next[i] = ^(ptr_gray_o >> i);
        end
    end

    logic [PTR_W-1:0] gray_prev;
    logic             chk_en;
    logic [PTR_W-1:0] gray_diff;
    logic             violation;

    assign gray_diff = ptr_gray_o ^ gray_prev;
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign violation = chk_en && ((gray_diff & (gray_diff - PTR_ONE)) != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_bin_o  <= '0;
            ptr_upd_o  <= 1'b0;
            gray_prev  <= '0;
            chk_en     <= 1'b0;
            gray_err_o <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            ptr_bin_o <= bin_next;
            ptr_upd_o <= (bin_next != ptr_bin_o);
            gray_prev <= ptr_gray_o;
            chk_en    <= 1'b1;
            if (violation) begin
                gray_err_o <= 1'b1;
                if (err_clr_i) begin
                    err_cnt_o <= CNT_ONE;
                end else if (err_cnt_o != CNT_MAX) begin
                    err_cnt_o <= err_cnt_o + CNT_ONE;
                end
            end else if (err_clr_i) begin
                gray_err_o <= 1'b0;
                err_cnt_o  <= '0;
            end
        end
    end

endmodule

`default_nettype wire
